// File: rtl/regfile_2w2r_sweep.sv
// Parametrised two-write / two-read register file with optional hardwired-zero
// R0, optional same-cycle write-to-read forwarding, and a sweep-clear engine
// that zeroes the array one entry per clock without using RESET.
module regfile_2w2r_sweep #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] SA,
   input  logic [ADDR_W-1:0] SB,
   output logic [DATA_W-1:0] OUTA,
   output logic [DATA_W-1:0] OUTB,
   input  logic              LDA,
   input  logic [ADDR_W-1:0] DRA,
   input  logic [DATA_W-1:0] DINA,
   input  logic              LDB,
   input  logic [ADDR_W-1:0] DRB,
   input  logic [DATA_W-1:0] DINB,
   input  logic              CLR,
   output logic              BUSY,
   output logic              DROP
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;
   logic              drop_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic wr_a_en;
   logic wr_b_en;
   logic sweep_en;

   assign sweep_en = (state_q == SWEEP);

   // Write acceptance: blocked while sweeping, port A wins a same-address collision.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wr_a_en = LDA && !busy_q;
      wr_b_en = LDB && !busy_q && !(LDA && (DRA == DRB));
      if (ZERO_R0 != 0) begin
         if (DRA == '0) wr_a_en = 1'b0;
         if (DRB == '0) wr_b_en = 1'b0;
      end
   end

   // Next array contents: sweep clear, else port A, else port B.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (sweep_en && (ptr_q == ADDR_W'(i))) begin
            mem_d[i] = '0;
         end else if (wr_a_en && (DRA == ADDR_W'(i))) begin
            mem_d[i] = DINA;
         end else if (wr_b_en && (DRB == ADDR_W'(i))) begin
            mem_d[i] = DINB;
         end
      end
   end

   // Register array storage.
   always_ff @(posedge CLK or posedge RESET) begin
      // NOTE: the array must come up zeroed on RESET, so it lives in flops with an async reset, not in a RAM macro.
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Sweep-clear FSM with registered BUSY and DROP.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= busy_q && (LDA || LDB);
         case (state_q)
            IDLE: begin
               if (CLR) begin
                  state_q <= SWEEP;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               ptr_q <= ptr_q + ADDR_W'(1);
               if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read port A: stored value, optionally forwarded write data, R0 forced to zero.
   always_comb begin
      OUTA = mem_q[SA];
      if (BYPASS != 0) begin
         if (wr_a_en && (DRA == SA)) begin
            OUTA = DINA;
         end else if (wr_b_en && (DRB == SA)) begin
            OUTA = DINB;
         end
      end
      if ((ZERO_R0 != 0) && (SA == '0)) OUTA = '0;
   end

   // Read port B: same structure as port A, independent address.
   always_comb begin
      OUTB = mem_q[SB];
      if (BYPASS != 0) begin
         if (wr_a_en && (DRA == SB)) begin
            OUTB = DINA;
         end else if (wr_b_en && (DRB == SB)) begin
            OUTB = DINB;
         end
      end
      if ((ZERO_R0 != 0) && (SB == '0)) OUTB = '0;
   end

   assign BUSY = busy_q;
   assign DROP = drop_q;

endmodule

// File: tb/tb_regfile_2w2r_sweep.sv
// Directed bench for regfile_2w2r_sweep: one default instance and one with
// ZERO_R0=1 / BYPASS=1, both driven by the same stimulus.
module tb_regfile_2w2r_sweep;

   logic       CLK;
   logic       RESET;
   logic [2:0] SA, SB, DRA, DRB;
   logic [7:0] DINA, DINB;
   logic       LDA, LDB, CLR;

   logic [7:0] outa0, outb0, outa1, outb1;
   logic       busy0, drop0, busy1, drop1;

   int errors = 0;
   int checks = 0;

   regfile_2w2r_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(0)) u_dut0 (
      .CLK(CLK), .RESET(RESET), .SA(SA), .SB(SB), .OUTA(outa0), .OUTB(outb0),
      .LDA(LDA), .DRA(DRA), .DINA(DINA), .LDB(LDB), .DRB(DRB), .DINB(DINB),
      .CLR(CLR), .BUSY(busy0), .DROP(drop0)
   );

   regfile_2w2r_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .SA(SA), .SB(SB), .OUTA(outa1), .OUTB(outb1),
      .LDA(LDA), .DRA(DRA), .DINA(DINA), .LDB(LDB), .DRB(DRB), .DINB(DINB),
      .CLR(CLR), .BUSY(busy1), .DROP(drop1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      LDA = 1'b0; LDB = 1'b0; CLR = 1'b0;
   endtask

   initial begin
      int n;
      RESET = 1'b1;
      SA = '0; SB = '0; DRA = '0; DRB = '0; DINA = '0; DINB = '0;
      LDA = 1'b0; LDB = 1'b0; CLR = 1'b0;
      #2;
      for (int i = 0; i < 8; i++) begin
         SA = 3'(i);
         #1;
         check($sformatf("reset_r%0d", i), outa0, 8'h00);
      end
      check("reset_busy", {7'b0, busy0}, 8'h00);
      check("reset_drop", {7'b0, drop0}, 8'h00);
      #4 RESET = 1'b0;
      tick();

      // Single write via port A; bypass instance forwards before the edge.
      LDA = 1'b1; DRA = 3'd3; DINA = 8'hA5; SA = 3'd3;
      #1;
      check("pre_edge_nobyp_r3", outa0, 8'h00);
      check("pre_edge_byp_r3", outa1, 8'hA5);
      tick();
      idle_inputs();
      #1;
      check("wr_a_r3", outa0, 8'hA5);
      check("wr_a_r3_d1", outa1, 8'hA5);

      // Dual write, distinct addresses.
      LDA = 1'b1; DRA = 3'd1; DINA = 8'h11;
      LDB = 1'b1; DRB = 3'd6; DINB = 8'h66;
      tick();
      idle_inputs();
      SA = 3'd1; SB = 3'd6;
      #1;
      check("dual_a_r1", outa0, 8'h11);
      check("dual_b_r6", outb0, 8'h66);

      // Collision: port A wins, no DROP; bypass forwards port A data.
      LDA = 1'b1; DRA = 3'd2; DINA = 8'h3C;
      LDB = 1'b1; DRB = 3'd2; DINB = 8'hC3;
      SB = 3'd2;
      #1;
      check("coll_byp_fwd", outb1, 8'h3C);
      tick();
      idle_inputs();
      SA = 3'd2;
      #1;
      check("coll_r2", outa0, 8'h3C);
      check("coll_r2_d1", outa1, 8'h3C);
      check("coll_drop", {7'b0, drop0}, 8'h00);

      // Bypass versus stored read on R4.
      LDA = 1'b1; DRA = 3'd4; DINA = 8'h44;
      tick();
      SA = 3'd4; DINA = 8'h7E;
      #1;
      check("byp0_old_r4", outa0, 8'h44);
      check("byp1_fwd_r4", outa1, 8'h7E);
      tick();
      idle_inputs();
      #1;
      check("post_edge_r4", outa0, 8'h7E);

      // Writes to R0: ignored by the ZERO_R0 instance, including forwarding.
      LDA = 1'b1; DRA = 3'd0; DINA = 8'hFF;
      LDB = 1'b1; DRB = 3'd0; DINB = 8'hEE;
      SA = 3'd0; SB = 3'd0;
      #1;
      check("r0_byp_a", outa1, 8'h00);
      check("r0_byp_b", outb1, 8'h00);
      tick();
      idle_inputs();
      #1;
      check("r0_stored_d0", outa0, 8'hFF);
      check("r0_read_a_d1", outa1, 8'h00);
      check("r0_read_b_d1", outb1, 8'h00);
      check("r0_drop_d1", {7'b0, drop1}, 8'h00);

      // Asynchronous RESET mid-cycle.
      SA = 3'd3;
      #1;
      check("pre_async_r3", outa0, 8'hA5);
      RESET = 1'b1;
      #1;
      check("async_reset_a0", outa0, 8'h00);
      check("async_reset_a1", outa1, 8'h00);
      #2 RESET = 1'b0;
      tick();

      // Preload R0..R7 with 0x10..0x17.
      for (int i = 0; i < 4; i++) begin
         LDA = 1'b1; DRA = 3'(i);     DINA = 8'h10 + 8'(i);
         LDB = 1'b1; DRB = 3'(i + 4); DINB = 8'h14 + 8'(i);
         tick();
      end
      idle_inputs();
      SA = 3'd5;
      #1;
      check("preload_r5", outa0, 8'h15);

      // Sweep: cycle 1 of BUSY follows the CLR edge.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      check("sweep_busy_c1", {7'b0, busy0}, 8'h01);
      LDB = 1'b1; DRB = 3'd7; DINB = 8'hEE;
      tick();
      // Cycle 2: dropped write pulses DROP, R7 unchanged; re-request CLR.
      LDB = 1'b0; CLR = 1'b1; SA = 3'd7;
      #1;
      check("sweep_drop_c2", {7'b0, drop0}, 8'h01);
      check("sweep_r7_kept", outa0, 8'h17);
      tick();
      // Cycle 3: R0, R1 cleared, R5 still old.
      CLR = 1'b0; SA = 3'd5; SB = 3'd1;
      #1;
      check("sweep_drop_c3", {7'b0, drop0}, 8'h00);
      check("sweep_r5_c3", outa0, 8'h15);
      check("sweep_r1_c3", outb0, 8'h00);
      n = 3;
      for (int k = 0; k < 40 && busy0; k++) begin
         tick();
         if (busy0) n++;
      end
      check("sweep_len", 8'(n), 8'd8);
      check("sweep_busy_d1_done", {7'b0, busy1}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         SA = 3'(i);
         #1;
         check($sformatf("sweep_clr_r%0d", i), outa0, 8'h00);
      end

      // RESET during cycle 4 of a sweep aborts it immediately.
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      tick(); tick(); tick();
      check("abort_busy_pre", {7'b0, busy0}, 8'h01);
      #2 RESET = 1'b1;
      #1;
      check("abort_busy", {7'b0, busy0}, 8'h00);
      #1 RESET = 1'b0;
      tick();
      check("abort_stays_idle", {7'b0, busy0}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_2w2r_sweep.md
Name: regfile_2w2r_sweep

Overview:
- Parametrised general-purpose register file for the single-core datapath.
- Generalises the 8x8 two-read/one-write register file:
  - configurable data width and depth
  - two independent write ports with a fixed collision priority
  - optional hardwired-zero R0
  - optional same-cycle write-to-read bypass
  - sequential sweep-clear engine that zeroes the array one entry per cycle without asserting RESET.

Parameters:
- DATA_W, 8, width of each register and of all data ports.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores all writes.
- BYPASS, 0, 1 = read ports forward same-cycle accepted write data.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- SA  input  ADDR_W  read port A address
- SB  input  ADDR_W  read port B address
- OUTA  output  DATA_W  read port A data, combinational
- OUTB  output  DATA_W  read port B data, combinational
- LDA  input  1  write port A enable
- DRA  input  ADDR_W  write port A destination
- DINA  input  DATA_W  write port A data
- LDB  input  1  write port B enable
- DRB  input  ADDR_W  write port B destination
- DINB  input  DATA_W  write port B data
- CLR  input  1  sweep-clear request, sampled on rising edge
- BUSY  output  1  sweep-clear in progress, registered
- DROP  output  1  one-cycle registered pulse: a write was discarded because BUSY was high

Behaviour:
- Reset:
  - RESET is asynchronous, active-high; clock is CLK.
  - RESET=1 immediately zeroes all DEPTH registers, BUSY=0, DROP=0, state=IDLE, sweep pointer PTR=0.
  - RESET mid-sweep aborts the sweep.
- Reads:
  - OUTA = reg[SA] and OUTB = reg[SB], combinational with zero latency.
  - Each read port is fully independent; SA==SB is legal.
- ZERO_R0=1:
  - Any read of address 0 returns 0, including a bypassed read.
  - Writes to address 0 are silently ignored; DROP is not asserted for these.
- Write acceptance:
  - Port A write accepted when LDA=1 and BUSY=0.
  - Port B write accepted when LDB=1 and BUSY=0.
  - An accepted write updates reg[DRx] at the rising edge.
- Write collision: LDA=LDB=1 with DRA==DRB writes DINA; DINB is discarded without asserting DROP.
- BYPASS=1:
  - If an accepted write targets SA in the current cycle, OUTA shows that write data; likewise OUTB for SB.
  - On a collision, port A data is forwarded.
  - No forwarding while BUSY=1.
- BYPASS=0: reads show stored contents only; write data is visible the cycle after the edge.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE, CLR=1 at edge: go to SWEEP, PTR<=0, BUSY<=1.
    - Writes accepted at that same edge still land and are then overwritten by the sweep.
  - SWEEP, each edge: reg[PTR]<=0, PTR<=PTR+1.
    - When PTR==DEPTH-1 is cleared: go to IDLE, BUSY<=0, PTR wraps to 0.
    - BUSY is high for exactly DEPTH cycles.
  - CLR while BUSY=1 is ignored and does not restart the sweep.
  - CLR held high continuously starts a new sweep on the first edge after BUSY falls.
- Writes during SWEEP:
  - LDA or LDB high while BUSY=1 is discarded.
  - DROP<=1 for the following cycle; otherwise DROP<=0.
- Reads during SWEEP return current array contents: already-cleared entries read 0, the rest read their old value.
- Widths: no arithmetic is performed on data. PTR is ADDR_W bits with natural wrap.

Test Plan:
- Reset and readback (defaults):
  - Apply RESET; all SA values read 0.
  - Write 0xA5 to R3 via port A; the next cycle SA=3 shows 0xA5.
  - RESET asserted mid-cycle zeroes OUTA without waiting for a clock edge.
- Dual write, no collision: port A writes R1=0x11 and port B writes R6=0x66 in one cycle; the next cycle OUTA(SA=1)=0x11 and OUTB(SB=6)=0x66.
- Collision: DRA=DRB=2, DINA=0x3C, DINB=0xC3 -> R2=0x3C, DROP=0.
- Bypass (BYPASS=1): SA=4 with LDA=1, DRA=4, DINA=0x7E in the same cycle -> OUTA=0x7E before the edge.
  - With BYPASS=0, OUTA shows the old R4 before the edge.
- ZERO_R0=1: write 0xFF to R0 -> R0 reads 0 on both ports, including the bypass path; DROP=0.
- Sweep clear:
  - Preload all 8 registers with 0x10..0x17, pulse CLR.
  - BUSY is high exactly 8 cycles; afterwards all registers read 0.
  - During cycle 3 of BUSY, R5 still reads 0x15.
  - A port B write issued during BUSY has no effect and DROP pulses for 1 cycle.
  - A second CLR pulse during BUSY leaves the length at 8 cycles.
  - RESET at cycle 4 forces BUSY=0 immediately.
